// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if
// Fetch, load/store and memory-side signals of the shared data-memory port.
// Revision: 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ack;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_ack, ls_rdata, ls_err,
        output mem_we, mem_a, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_ack, ls_rdata, ls_err,
        input  mem_we, mem_a, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
// Round-robin arbiter/sequencer sharing one synchronous-read memory between
// instruction fetch and load/store; every access takes IDLE->ISSUE->RESP.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t r_state;
    logic   r_owner;        // 0 = fetch, 1 = load/store
    logic   r_last_owner;
    logic   r_err_q;
    logic   r_issue;
    logic   r_mem_we;
    logic   r_if_ack;
    logic   r_ls_ack;
    logic   r_if_err;
    logic   r_ls_err;
    logic   r_if_rd;
    logic   r_ls_rd;

    logic              w_any_req;
    logic              w_ls_win;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_win_mis;

    // On a tie the port that did not win last time gets the grant.
    assign w_any_req  = bus.if_req | bus.ls_req;
    assign w_ls_win   = bus.ls_req & (~bus.if_req | ~r_last_owner);
    assign w_win_addr = w_ls_win ? bus.ls_addr : bus.if_addr;
    assign w_win_mis  = |w_win_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_err_q      <= 1'b0;
            r_issue      <= 1'b0;
            r_mem_we     <= 1'b0;
            r_if_ack     <= 1'b0;
            r_ls_ack     <= 1'b0;
            r_if_err     <= 1'b0;
            r_ls_err     <= 1'b0;
            r_if_rd      <= 1'b0;
            r_ls_rd      <= 1'b0;
        end else begin
            r_issue  <= 1'b0;
            r_mem_we <= 1'b0;
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            r_if_err <= 1'b0;
            r_ls_err <= 1'b0;
            r_if_rd  <= 1'b0;
            r_ls_rd  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_ISSUE;
                        r_owner      <= w_ls_win;
                        r_last_owner <= w_ls_win;
                        r_err_q      <= w_win_mis;
                        r_issue      <= 1'b1;
                        r_mem_we     <= w_ls_win & bus.ls_we & ~w_win_mis;
                    end
                end
                S_ISSUE: begin
                    r_state  <= S_RESP;
                    r_if_ack <= ~r_owner;
                    r_ls_ack <= r_owner;
                    r_if_err <= ~r_owner & r_err_q;
                    r_ls_err <= r_owner & r_err_q;
                    // Read data is only forwarded for aligned loads and fetches.
                    r_if_rd  <= ~r_owner & ~r_err_q;
                    r_ls_rd  <= r_owner & ~bus.ls_we & ~r_err_q;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_a     = r_issue ? (r_owner ? bus.ls_addr : bus.if_addr) : {ADDR_W{1'b0}};
    assign bus.mem_wdata = r_issue ? bus.ls_wdata : {DATA_W{1'b0}};

    assign bus.if_ack    = r_if_ack;
    assign bus.if_err    = r_if_err;
    assign bus.if_rdata  = r_if_rd ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.ls_ack    = r_ls_ack;
    assign bus.ls_err    = r_ls_err;
    assign bus.ls_rdata  = r_ls_rd ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule
`default_nettype wire
